// File: rtl/screen_timing_gen.sv
// ---------------------------------------------------------------------------
// screen_timing_gen
//   Runtime-programmable raster timing generator for the clk28 domain.
//   A 2-bit sub-pixel phase divides clk28 into the 14/7 MHz enables and steps
//   the pixel counter hc. hc wraps at h_last and steps the line counter vc,
//   which wraps at v_last. Sync, blank and raster-interrupt windows are
//   compared against programmable edges and registered one clk28 later.
//
//   Timing registers (index: name), each with a shadow and an active copy:
//     0 h_last  1 h_blank_start  2 h_sync_start  3 h_sync_end  4 h_blank_end
//     5 v_last  6 v_sync_start   7 v_sync_end    8 int_line    9 int_col
//   The CPU writes the shadow copy. The active copy is loaded from the shadow
//   only at the frame wrap, so a timing change never tears a frame.
//
//   Build option: define SCREEN_RASTER_INT_EN to include the raster interrupt
//   (registers 8/9 and the int_n pulse). Without it int_n is tied high and
//   writes to indices 8/9 are ignored.
//
// Ports:
//   clk28        in   28 MHz master clock
//   rst          in   asynchronous active-high reset
//   cfg_we       in   shadow register write strobe
//   cfg_addr     in   shadow register index (10-15 ignored)
//   cfg_data     in   write data, truncated to the register width
//   hc, vc       out  pixel / line counters
//   ck14, ck7    out  clock-phase enables (1 of 2 / 1 of 4 clk28 cycles)
//   hsync_n, vsync_n, csync_n  out  registered syncs, active-low
//   blank        out  registered blanking
//   line_start   out  1-cycle pulse after the hc wrap edge
//   frame_start  out  1-cycle pulse after the hc+vc wrap edge
//   blink        out  MSB of the frame counter
//   int_n        out  raster interrupt, active-low
// ---------------------------------------------------------------------------
module screen_timing_gen #(
  parameter int  HC_W    = 9,
  parameter int  VC_W    = 9,
  parameter int  BLINK_W = 5,
  parameter int  INT_LEN = 32,
  localparam int CFG_W   = (HC_W > VC_W) ? HC_W : VC_W
) (
  input  logic             clk28,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [CFG_W-1:0] cfg_data,
  output logic [HC_W-1:0]  hc,
  output logic [VC_W-1:0]  vc,
  output logic             ck14,
  output logic             ck7,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             csync_n,
  output logic             blank,
  output logic             line_start,
  output logic             frame_start,
  output logic             blink,
  output logic             int_n
);

  // 48K defaults; narrower counters keep the low bits.
  localparam logic [HC_W-1:0] RST_H_LAST = HC_W'(447);
  localparam logic [HC_W-1:0] RST_H_BS   = HC_W'(312);
  localparam logic [HC_W-1:0] RST_H_SS   = HC_W'(329);
  localparam logic [HC_W-1:0] RST_H_SE   = HC_W'(362);
  localparam logic [HC_W-1:0] RST_H_BE   = HC_W'(408);
  localparam logic [VC_W-1:0] RST_V_LAST = VC_W'(311);
  localparam logic [VC_W-1:0] RST_V_SS   = VC_W'(248);
  localparam logic [VC_W-1:0] RST_V_SE   = VC_W'(256);

`ifdef SCREEN_RASTER_INT_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  if (INT_LEN < 1 || INT_LEN >= (1 << HC_W)) begin : g_bad_int_len
    $error("screen_timing_gen: INT_LEN out of range");
  end

  // Half-open window test; start >= end yields an empty window.
  function automatic logic in_window(input logic [CFG_W-1:0] pos,
                                     input logic [CFG_W-1:0] w_start,
                                     input logic [CFG_W-1:0] w_end);
    return (pos >= w_start) && (pos < w_end);
  endfunction

  logic [1:0]      sub;
  logic [HC_W-1:0] h_last_s, h_bs_s, h_ss_s, h_se_s, h_be_s;
  logic [HC_W-1:0] h_last_a, h_bs_a, h_ss_a, h_se_a, h_be_a;
  logic [VC_W-1:0] v_last_s, v_ss_s, v_se_s;
  logic [VC_W-1:0] v_last_a, v_ss_a, v_se_a;
  logic            commit_pend;
  logic            cfg_hit;
  logic            hc_wrap;
  logic            frame_wrap;
  logic            hs_win_p0, hb_win_p0, vs_win_p0;
  logic [BLINK_W-1:0] frame_cnt;

  assign cfg_hit    = cfg_we && (cfg_addr <= LAST_IDX);
  assign hc_wrap    = (sub == 2'd3) && (hc == h_last_a);
  assign frame_wrap = hc_wrap && (vc == v_last_a);

  assign ck14  = sub[0];
  assign ck7   = sub[0] & sub[1];
  assign blink = frame_cnt[BLINK_W-1];

  // Shadow register file, CPU side.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      h_last_s <= RST_H_LAST;
      h_bs_s   <= RST_H_BS;
      h_ss_s   <= RST_H_SS;
      h_se_s   <= RST_H_SE;
      h_be_s   <= RST_H_BE;
      v_last_s <= RST_V_LAST;
      v_ss_s   <= RST_V_SS;
      v_se_s   <= RST_V_SE;
    end else if (cfg_we) begin
      case (cfg_addr)
        4'd0:    h_last_s <= HC_W'(cfg_data);
        4'd1:    h_bs_s   <= HC_W'(cfg_data);
        4'd2:    h_ss_s   <= HC_W'(cfg_data);
        4'd3:    h_se_s   <= HC_W'(cfg_data);
        4'd4:    h_be_s   <= HC_W'(cfg_data);
        4'd5:    v_last_s <= VC_W'(cfg_data);
        4'd6:    v_ss_s   <= VC_W'(cfg_data);
        4'd7:    v_se_s   <= VC_W'(cfg_data);
        default: ;
      endcase
    end
  end

  // A write landing on the wrap edge keeps the flag set, so it is picked up
  // at the following wrap while this one loads the pre-write shadow.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      commit_pend <= 1'b0;
    end else if (cfg_hit) begin
      commit_pend <= 1'b1;
    end else if (frame_wrap) begin
      commit_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      h_last_a <= RST_H_LAST;
      h_bs_a   <= RST_H_BS;
      h_ss_a   <= RST_H_SS;
      h_se_a   <= RST_H_SE;
      h_be_a   <= RST_H_BE;
      v_last_a <= RST_V_LAST;
      v_ss_a   <= RST_V_SS;
      v_se_a   <= RST_V_SE;
    end else if (frame_wrap && commit_pend) begin
      h_last_a <= h_last_s;
      h_bs_a   <= h_bs_s;
      h_ss_a   <= h_ss_s;
      h_se_a   <= h_se_s;
      h_be_a   <= h_be_s;
      v_last_a <= v_last_s;
      v_ss_a   <= v_ss_s;
      v_se_a   <= v_se_s;
    end
  end

  // Stage p0: counters and window decode.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      sub <= 2'd0;
      hc  <= '0;
      vc  <= '0;
    end else begin
      sub <= sub + 2'd1;
      if (hc_wrap) begin
        hc <= '0;
        vc <= (vc == v_last_a) ? '0 : vc + 1'b1;
      end else if (sub == 2'd3) begin
        hc <= hc + 1'b1;
      end
    end
  end

  assign hs_win_p0 = in_window(CFG_W'(hc), CFG_W'(h_ss_a), CFG_W'(h_se_a));
  assign hb_win_p0 = in_window(CFG_W'(hc), CFG_W'(h_bs_a), CFG_W'(h_be_a));
  assign vs_win_p0 = in_window(CFG_W'(vc), CFG_W'(v_ss_a), CFG_W'(v_se_a));

  // Stage p1: registered strobes, one clk28 behind the counters.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      csync_n     <= 1'b1;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hsync_n     <= ~hs_win_p0;
      vsync_n     <= ~vs_win_p0;
      csync_n     <= ~(hs_win_p0 ^ vs_win_p0);
      blank       <= hb_win_p0 | vs_win_p0;
      line_start  <= hc_wrap;
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

`ifdef SCREEN_RASTER_INT_EN
  localparam int IC_W = $clog2(INT_LEN + 1);

  logic [VC_W-1:0] int_line_s, int_line_a;
  logic [HC_W-1:0] int_col_s, int_col_a;
  logic [IC_W-1:0] int_cnt;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      int_line_s <= '0;
      int_col_s  <= '0;
    end else if (cfg_we && cfg_addr == 4'd8) begin
      int_line_s <= VC_W'(cfg_data);
    end else if (cfg_we && cfg_addr == 4'd9) begin
      int_col_s  <= HC_W'(cfg_data);
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      int_line_a <= '0;
      int_col_a  <= '0;
    end else if (frame_wrap && commit_pend) begin
      int_line_a <= int_line_s;
      int_col_a  <= int_col_s;
    end
  end

  // The count is in hc steps and ignores line/frame wrap; a fresh match
  // reloads it even while a pulse is running.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      int_cnt <= '0;
      int_n   <= 1'b1;
    end else if (sub == 2'd0 && hc == int_col_a && vc == int_line_a) begin
      int_cnt <= IC_W'(INT_LEN);
      int_n   <= 1'b0;
    end else if (sub == 2'd3 && int_cnt != '0) begin
      int_cnt <= int_cnt - IC_W'(1);
      if (int_cnt == IC_W'(1)) begin
        int_n <= 1'b1;
      end
    end
  end
`else
  assign int_n = 1'b1;
`endif

endmodule

// File: tb/tb_screen_timing_gen.sv
// Bench for screen_timing_gen. The line counter is narrowed to 5 bits so the
// power-on frame (48K defaults truncated: v_last = 311 mod 32 = 23, vsync
// window 24..0 empty) is short enough to run through and reprogram.
module tb_screen_timing_gen;
  localparam int HC_W    = 9;
  localparam int VC_W    = 5;
  localparam int BLINK_W = 5;
  localparam int INT_LEN = 32;
  localparam int CFG_W   = 9;
  localparam int DEF_HT  = 448;
  localparam int DEF_VT  = (311 % (1 << VC_W)) + 1;

  logic             clk28 = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [3:0]       cfg_addr = '0;
  logic [CFG_W-1:0] cfg_data = '0;
  logic [HC_W-1:0]  hc;
  logic [VC_W-1:0]  vc;
  logic ck14, ck7, hsync_n, vsync_n, csync_n, blank;
  logic line_start, frame_start, blink, int_n;

  screen_timing_gen #(.HC_W(HC_W), .VC_W(VC_W), .BLINK_W(BLINK_W), .INT_LEN(INT_LEN)) dut (
    .clk28(clk28), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .hc(hc), .vc(vc), .ck14(ck14), .ck7(ck7), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .csync_n(csync_n), .blank(blank), .line_start(line_start), .frame_start(frame_start),
    .blink(blink), .int_n(int_n)
  );

  always #5 clk28 = ~clk28;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];
  int cyc = 0;
  int nfs = 0;
  int r_hs_first, r_hs_last, r_hs_cnt, r_vs_first, r_vs_last;
  int r_bad_hs, r_bad_vs, r_bad_cs, r_bad_bl, r_int_lo, r_int_hi;

  task automatic push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs);
    logic signed [31:0] exp_v;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s: timed out waiting for the DUT", tag);
  endtask

  // All sampling happens here, on the falling edge.
  task automatic step();
    @(negedge clk28);
    cyc++;
    if (rst) nfs = 0;
    else if (frame_start) nfs++;
  endtask

  task automatic wait_pulse(input bit fs, input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!(fs ? frame_start : line_start) && cycles < budget);
    if (!(fs ? frame_start : line_start)) timeout_fail(fs ? "wait_frame_start" : "wait_line_start");
  endtask

  task automatic cfg(input int a, input int d);
    cfg_addr = 4'(a);
    cfg_data = CFG_W'(d);
    cfg_we   = 1'b1;
    step();
    cfg_we   = 1'b0;
  endtask

  // Walks n_lines lines from the next line/frame start, sampling each pixel
  // at sub-phase 2 and comparing against the window rules for the given edges.
  task automatic scan(input bit fs, input int ht, input int vt, input int n_lines,
                      input int hbs, input int hbe, input int hss, input int hse,
                      input int vss, input int vse);
    int c, h, v, vv;
    bit ehs, evs, ebl;
    r_hs_first = -1; r_hs_last = -1; r_hs_cnt = 0; r_vs_first = -1; r_vs_last = -1;
    r_bad_hs = 0; r_bad_vs = 0; r_bad_cs = 0; r_bad_bl = 0; r_int_lo = -1; r_int_hi = -1;
    wait_pulse(fs, 2000, c);
    for (int n = 0; n < n_lines * ht * 4; n++) begin
      if (n % 4 == 2) begin
        h   = (n / 4) % ht;
        v   = (n / 4) / ht;
        vv  = v % vt;
        ehs = (h >= hss) && (h < hse);
        evs = (vv >= vss) && (vv < vse);
        ebl = ((h >= hbs) && (h < hbe)) || evs;
        if (hsync_n === 1'b0) begin
          if (r_hs_first < 0) r_hs_first = h;
          r_hs_last = h;
          r_hs_cnt++;
        end
        if (vsync_n === 1'b0) begin
          if (r_vs_first < 0) r_vs_first = vv;
          r_vs_last = vv;
        end
        if (hsync_n !== !ehs) r_bad_hs++;
        if (vsync_n !== !evs) r_bad_vs++;
        if (csync_n !== !(ehs ^ evs)) r_bad_cs++;
        if (blank !== ebl) r_bad_bl++;
        if (int_n === 1'b0 && r_int_lo < 0) r_int_lo = v * 1000 + h;
        if (int_n === 1'b1 && r_int_lo >= 0 && r_int_hi < 0) r_int_hi = v * 1000 + h;
      end
      step();
    end
  endtask

  initial begin
    int c, t0, g;

    // Reset state
    repeat (3) step();
    push(0); chk("rst_hc", hc);
    push(0); chk("rst_vc", vc);
    push(1); chk("rst_hsync_n", hsync_n);
    push(1); chk("rst_vsync_n", vsync_n);
    push(1); chk("rst_csync_n", csync_n);
    push(0); chk("rst_blank", blank);
    push(0); chk("rst_pulses", {line_start, frame_start});
    push(0); chk("rst_blink", blink);
    push(1); chk("rst_int_n", int_n);

    // Phase enables: sub runs 1,2,3,0 after release
    rst = 1'b0;
    t0  = cyc;
    push(2); push(0); push(3); push(0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ck14_ck7", {ck14, ck7});
    end

    // Default line timing
    push(DEF_HT * 4);
    wait_pulse(1'b0, 2000, c);
    chk("first_line_start_cycle", cyc - t0);
    push(DEF_HT * 4);
    wait_pulse(1'b0, 2000, c);
    chk("default_line_period", c);

    // Mid-frame reprogramming; must not affect the running frame
    cfg(0, 15); cfg(1, 12); cfg(2, 13); cfg(3, 14);
    cfg(4, 15); cfg(5, 7);  cfg(6, 5);  cfg(7, 6);
    cfg(12, 3);
    scan(1'b0, DEF_HT, 1, 1, 312, 408, 329, 362, 0, 0);
    push(329); chk("default_hsync_first", r_hs_first);
    push(361); chk("default_hsync_last", r_hs_last);
    push(0);   chk("default_hsync_bad", r_bad_hs);
    push(0);   chk("default_csync_bad", r_bad_cs);
    push(0);   chk("default_blank_bad", r_bad_bl);
    push(1);   chk("line_period_pre_commit", line_start);

    push(DEF_HT * 4 * DEF_VT);
    wait_pulse(1'b1, 45000, c);
    chk("first_frame_start_cycle", cyc - t0);

    // New timing: 16 pixels x 8 lines
    push(16 * 4 * 8);
    wait_pulse(1'b1, 1200, c);
    chk("committed_frame_period", c);
    push(16 * 4);
    wait_pulse(1'b0, 200, c);
    chk("committed_line_period", c);
    scan(1'b1, 16, 8, 8, 12, 15, 13, 14, 5, 6);
    push(13); chk("small_hsync_first", r_hs_first);
    push(5);  chk("small_vsync_first", r_vs_first);
    push(5);  chk("small_vsync_last", r_vs_last);
    push(0);  chk("small_hsync_bad", r_bad_hs);
    push(0);  chk("small_vsync_bad", r_bad_vs);
    push(0);  chk("small_csync_bad", r_bad_cs);
    push(0);  chk("small_blank_bad", r_bad_bl);

    // Write coincident with a committing wrap edge
    cfg(4, 15);
    g = 0;
    while (!(hc == 15 && vc == 7 && ck14 && ck7) && g < 1200) begin
      step();
      g++;
    end
    if (g >= 1200) timeout_fail("find_frame_wrap");
    cfg(5, 3);
    push(1);  chk("wrap_write_frame_start", frame_start);
    push(16 * 4 * 8);
    wait_pulse(1'b1, 1200, c);
    chk("wrap_write_next_frame", c);
    push(16 * 4 * 4);
    wait_pulse(1'b1, 1200, c);
    chk("wrap_write_following_frame", c);

    // Empty hsync window: csync follows vsync alone
    cfg(2, 10); cfg(3, 10); cfg(5, 7);
    scan(1'b1, 16, 8, 8, 12, 15, 10, 10, 5, 6);
    push(0); chk("empty_hsync_count", r_hs_cnt);
    push(0); chk("empty_hsync_csync_bad", r_bad_cs);
    push(5); chk("empty_hsync_vsync_first", r_vs_first);
    push(0); chk("empty_hsync_blank_bad", r_bad_bl);

    // Raster interrupt at (7,8) spanning into the next frame
    cfg(8, 7); cfg(9, 8);
    scan(1'b1, 16, 8, 16, 12, 15, 10, 10, 5, 6);
`ifdef SCREEN_RASTER_INT_EN
    push(7 * 1000 + 8);       chk("int_low_start", r_int_lo);
    push(9 * 1000 + 8);       chk("int_high_again", r_int_hi);
`else
    push(-1);                 chk("int_never_low", r_int_lo);
`endif

    // Blink is the MSB of a 5-bit frame counter
    g = 0;
    while (nfs < 15 && g < 20) begin
      wait_pulse(1'b1, 1200, c);
      g++;
    end
    push(0); chk("blink_after_15", blink);
    wait_pulse(1'b1, 1200, c);
    push(1); chk("blink_after_16", blink);

    // Asynchronous reset in the vsync line
    g = 0;
    while (!(hc == 9 && vc == 5) && g < 1200) begin
      step();
      g++;
    end
    if (g >= 1200) timeout_fail("find_reset_point");
    push(0); chk("pre_rst_vsync_n", vsync_n);
    #2 rst = 1'b1;
    #1;
    push(0); chk("async_rst_hc", hc);
    push(0); chk("async_rst_vc", vc);
    push(1); chk("async_rst_vsync_n", vsync_n);
    push(1); chk("async_rst_csync_n", csync_n);
    push(0); chk("async_rst_blank", blank);
    push(0); chk("async_rst_blink", blink);
    push(0); chk("async_rst_ck", {ck14, ck7});
    push(1); chk("async_rst_int_n", int_n);
    step(); step();
    rst = 1'b0;
    t0  = cyc;
    push(DEF_HT * 4);
    wait_pulse(1'b0, 2000, c);
    chk("post_rst_default_line", cyc - t0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
